lobster_cache_ctrl: RTL and testbench

// Sequences and shares one lobster_cache instance among NUM_REQ requesters (fetch, load/store).

---
 rtl/lobster_cache_pkg.sv | 27 ++
 rtl/lobster_cache_ctrl_rr_arbiter.sv | 32 +++
 rtl/lobster_cache_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_lobster_cache_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lobster_cache_pkg.sv
// Shared types and hash for lobster_cache and its controller.
// The hash folds the address so both blocks index entries identically.
package lobster_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        WR_REQ,
        WR_WAIT,
        FLUSH
    } ctrl_state_e;

    localparam int HASH_C1 = 13;
    localparam int HASH_C2 = 26;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] lobster_cache_hash(input logic [63:0] a);
        return 32'(a ^ (a >> HASH_C1) ^ (a >> HASH_C2));
    endfunction

endpackage

// File: rtl/lobster_cache_ctrl_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer wins.
// Produces a one-hot grant plus its binary index.
module lobster_rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/lobster_cache_ctrl.sv
// Shares one lobster_cache among several requesters; tag shadow makes hits exact.
// Misses fill from memory, writes go through and allocate, flush sweeps every entry.
module lobster_cache_ctrl
    import lobster_cache_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 36,
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_ENTRIES = 8192
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    input  logic                          flush_req,
    output logic                          flush_busy,
    output logic                          cache_we,
    output logic                          cache_inv,
    output logic [ADDR_WIDTH-1:0]         cache_addr_in,
    output logic [ADDR_WIDTH-1:0]         cache_addr_out,
    output logic [DATA_WIDTH-1:0]         cache_data_in,
    input  logic [DATA_WIDTH-1:0]         cache_data_out,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_we,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr,
    output logic [DATA_WIDTH-1:0]         mem_req_wdata,
    input  logic                          mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]         mem_resp_data
);

    localparam int IDX_W = idx_width(NUM_ENTRIES);
    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    ctrl_state_e state_q, state_d;

    logic [PW-1:0]         id_q, id_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  wr_alloc_q, wr_alloc_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    logic [NUM_ENTRIES-1:0] shadow_valid_q;
    logic [ADDR_WIDTH-1:0]  shadow_tag_q [NUM_ENTRIES];

    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [IDX_W-1:0]   idx;
    logic               hit;
    logic               sh_set;
    logic               sh_clr;

    lobster_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign idx = IDX_W'(lobster_cache_hash(64'(addr_q)));
    assign hit = shadow_valid_q[idx] && (shadow_tag_q[idx] == addr_q);

    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign flush_busy     = (state_q == FLUSH);
    assign cache_addr_out = addr_q;

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fill_d       = fill_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        wr_alloc_d   = wr_alloc_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        flush_pend_d = flush_pend_q;
        req_ready     = '0;
        cache_we      = 1'b0;
        cache_inv     = 1'b0;
        cache_addr_in = '0;
        cache_data_in = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        sh_set        = 1'b0;
        sh_clr        = 1'b0;
        // A flush arriving mid-transaction waits for it to finish
        if (flush_req && state_q != IDLE && state_q != FLUSH) begin
            flush_pend_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (flush_req || flush_pend_q) begin
                    state_d      = FLUSH;
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                end else if (gnt_any) begin
                    req_ready = gnt;
                    id_d      = gnt_idx;
                    we_d      = req_we[gnt_idx];
                    addr_d    = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d   = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    ptr_d     = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    state_d    = WR_REQ;
                    wr_alloc_d = 1'b1;
                end else if (hit) begin
                    resp_valid_d[id_q] = 1'b1;
                    resp_data_d        = cache_data_out;
                    state_d            = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
                if (mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_resp_valid) begin
                    fill_d  = mem_resp_data;
                    state_d = FILL;
                end
            end
            FILL: begin
                cache_we           = 1'b1;
                cache_addr_in      = addr_q;
                cache_data_in      = fill_q;
                sh_set             = 1'b1;
                resp_valid_d[id_q] = 1'b1;
                resp_data_d        = fill_q;
                state_d            = IDLE;
            end
            WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = addr_q;
                mem_req_wdata = wdata_q;
                // Allocate into the cache only on the first cycle of the request
                if (wr_alloc_q) begin
                    cache_we      = 1'b1;
                    cache_addr_in = addr_q;
                    cache_data_in = wdata_q;
                    sh_set        = 1'b1;
                    wr_alloc_d    = 1'b0;
                end
                if (mem_req_ready) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_resp_valid) begin
                    resp_valid_d[id_q] = 1'b1;
                    resp_data_d        = '0;
                    state_d            = IDLE;
                end
            end
            FLUSH: begin
                cache_inv     = 1'b1;
                cache_addr_in = ADDR_WIDTH'(cnt_q);
                sh_clr        = 1'b1;
                if (cnt_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fill_q       <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            wr_alloc_q   <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fill_q       <= fill_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            wr_alloc_q   <= wr_alloc_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_valid_q <= '0;
        end else if (sh_clr) begin
            shadow_valid_q[cnt_q] <= 1'b0;
        end else if (sh_set) begin
            shadow_valid_q[idx] <= 1'b1;
        end
    end

    // Tags are only meaningful behind a valid bit, so they need no reset
    always_ff @(posedge clk) begin
        if (sh_set) shadow_tag_q[idx] <= addr_q;
    end

endmodule

// File: tb/tb_lobster_cache_ctrl.sv
// Directed bench for lobster_cache_ctrl with a cache array and memory responder.
// Expected values are hand-picked constants per scenario.
module tb_lobster_cache_ctrl;
    import lobster_cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_ready, req_we, resp_valid;
    logic [71:0]  req_addr;
    logic [127:0] req_wdata;
    logic [63:0]  resp_data;
    logic         flush_req, flush_busy;
    logic         cache_we, cache_inv;
    logic [35:0]  cache_addr_in, cache_addr_out;
    logic [63:0]  cache_data_in, cache_data_out;
    logic         mem_req_valid, mem_req_ready, mem_req_we;
    logic [35:0]  mem_req_addr;
    logic [63:0]  mem_req_wdata;
    logic         mem_resp_valid;
    logic [63:0]  mem_resp_data;

    int total = 0;
    int bad = 0;
    int mem_acc = 0;
    int bfm_stall = 0;
    int bfm_lat = 3;
    logic [63:0] bfm_data = '0;
    int mv_cyc, unstable;
    logic        snap_we;
    logic [35:0] snap_addr;
    logic [63:0] snap_wdata;
    logic [63:0] cmem [8192];

    always #5 clk = ~clk;

    lobster_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .cache_we(cache_we), .cache_inv(cache_inv),
        .cache_addr_in(cache_addr_in), .cache_addr_out(cache_addr_out),
        .cache_data_in(cache_data_in), .cache_data_out(cache_data_out),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    function automatic logic [12:0] hidx(input logic [35:0] a);
        logic [31:0] h;
        h = lobster_cache_hash(64'(a));
        return h[12:0];
    endfunction

    assign cache_data_out = cmem[hidx(cache_addr_out)];

    always @(posedge clk) begin
        if (cache_we) cmem[hidx(cache_addr_in)] <= cache_data_in;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin : mem_bfm
        int stall_left, lat;
        bit pend, acc;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        stall_left = 0; lat = 0; pend = 0; acc = 0;
        forever begin
            @(posedge clk); #1;
            mem_resp_valid = 0;
            if (!rst) begin
                pend = 0; acc = 0; mem_req_ready = 0;
            end else begin
                if (acc) begin
                    acc = 0; pend = 1; lat = bfm_lat; mem_acc++;
                end
                if (pend) begin
                    lat--;
                    if (lat <= 0) begin
                        mem_resp_valid = 1; mem_resp_data = bfm_data; pend = 0;
                    end
                end
                mem_req_ready = 0;
                if (!mem_req_valid) stall_left = bfm_stall;
                else if (!pend) begin
                    if (stall_left > 0) stall_left--;
                    else mem_req_ready = 1;
                end
            end
            @(negedge clk);
            acc = rst && mem_req_valid && mem_req_ready;
        end
    end

    task automatic issue(input int rid, input bit we, input logic [35:0] a,
                         input logic [63:0] d);
        int c;
        req_valid[rid] = 1'b1;
        req_we[rid] = we;
        req_addr[rid*36 +: 36] = a;
        req_wdata[rid*64 +: 64] = d;
        #1;
        c = 0;
        while (!req_ready[rid] && c < 50) begin
            @(posedge clk); #2;
            c++;
        end
        if (c >= 50) check("ready_timeout", 64'(c), 0);
        @(posedge clk); #1;
        req_valid[rid] = 1'b0;
    endtask

    task automatic wait_resp(input int rid, input int flush_at,
                             output int lat, output logic [63:0] data);
        lat = 1; mv_cyc = 0; unstable = 0;
        while (!resp_valid[rid] && lat < 200) begin
            flush_req = (lat == flush_at);
            if (mem_req_valid) begin
                mv_cyc++;
                if (mv_cyc == 1) begin
                    snap_we = mem_req_we; snap_addr = mem_req_addr;
                    snap_wdata = mem_req_wdata;
                end else if ({snap_we, snap_addr, snap_wdata} !==
                             {mem_req_we, mem_req_addr, mem_req_wdata}) begin
                    unstable++;
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        flush_req = 1'b0;
        if (lat >= 200) check("resp_timeout", 64'(lat), 0);
        data = resp_data;
    endtask

    task automatic do_req(input int rid, input bit we, input logic [35:0] a,
                          input logic [63:0] d, output int lat,
                          output logic [63:0] data, output int nm);
        int m0;
        m0 = mem_acc;
        issue(rid, we, a, d);
        wait_resp(rid, -1, lat, data);
        nm = mem_acc - m0;
    endtask

    initial begin : main
        int lat, nm, grants, mv, r0, r1, busy, inv, extra;
        logic [63:0] data;
        logic [1:0] exp_g;
        rst = 1'b0; req_valid = '0; req_we = '0; req_addr = '0;
        req_wdata = '0; flush_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 64'(|{req_ready, resp_valid, resp_data, flush_busy,
              cache_we, cache_inv, cache_addr_in, cache_addr_out, cache_data_in,
              mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: cold miss then hit
        bfm_data = 64'h1234_5678; bfm_lat = 3;
        do_req(0, 0, 36'hFFF80000, 0, lat, data, nm);
        check("t1_miss_data", data, 64'h1234_5678);
        check("t1_miss_memreq", 64'(nm), 1);
        check("t1_miss_we", 64'(snap_we), 0);
        check("t1_miss_addr", 64'(snap_addr), 64'hFFF80000);
        do_req(0, 0, 36'hFFF80000, 0, lat, data, nm);
        check("t1_hit_data", data, 64'h1234_5678);
        check("t1_hit_lat", 64'(lat), 2);
        check("t1_hit_nomem", 64'(mv_cyc), 0);

        // 2: aliasing addresses 0x40 and 0x2041 share an index
        bfm_data = 64'h4A;
        do_req(0, 0, 36'h40, 0, lat, data, nm);
        check("t2_a_data", data, 64'h4A);
        bfm_data = 64'h4B;
        do_req(0, 0, 36'h2041, 0, lat, data, nm);
        check("t2_b_miss", 64'(nm), 1);
        check("t2_b_data", data, 64'h4B);
        bfm_data = 64'h4C;
        do_req(0, 0, 36'h40, 0, lat, data, nm);
        check("t2_a_remiss", 64'(nm), 1);
        check("t2_a_data2", data, 64'h4C);

        // 3: both requesters saturating with hits
        bfm_data = 64'hA100;
        do_req(0, 0, 36'h100, 0, lat, data, nm);
        bfm_data = 64'hB200;
        do_req(1, 0, 36'h200, 0, lat, data, nm);
        req_addr = {36'h200, 36'h100}; req_we = 2'b00;
        req_valid = 2'b11;
        grants = 0; mv = 0; r0 = 0; r1 = 0;
        for (int c = 0; c < 200 && grants < 16; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                exp_g = (grants % 2 == 0) ? 2'b01 : 2'b10;
                check("t3_grant", 64'(req_ready), 64'(exp_g));
                grants++;
            end
            @(posedge clk); #1;
            if (mem_req_valid) mv++;
            if (resp_valid[0]) begin r0++; check("t3_d0", resp_data, 64'hA100); end
            if (resp_valid[1]) begin r1++; check("t3_d1", resp_data, 64'hB200); end
        end
        req_valid = 2'b00;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid[0]) r0++;
            if (resp_valid[1]) r1++;
        end
        check("t3_grants", 64'(grants), 16);
        check("t3_r0", 64'(r0), 8);
        check("t3_r1", 64'(r1), 8);
        check("t3_nomem", 64'(mv), 0);

        // 4: write with stalled memory, then hit on it
        bfm_stall = 5; bfm_lat = 2;
        do_req(1, 1, 36'h10, 64'hDEAD, lat, data, nm);
        check("t4_wr_resp", data, 0);
        check("t4_wr_memreq", 64'(nm), 1);
        check("t4_valid_cyc", 64'(mv_cyc), 6);
        check("t4_stable", 64'(unstable), 0);
        check("t4_we", 64'(snap_we), 1);
        check("t4_addr", 64'(snap_addr), 64'h10);
        check("t4_wdata", snap_wdata, 64'hDEAD);
        bfm_stall = 0;
        do_req(1, 0, 36'h10, 0, lat, data, nm);
        check("t4_hit_data", data, 64'hDEAD);
        check("t4_hit_lat", 64'(lat), 2);
        check("t4_hit_nomem", 64'(nm), 0);

        // 5: flush arriving during a miss
        bfm_lat = 10; bfm_data = 64'h3030;
        issue(0, 0, 36'h300, 0);
        wait_resp(0, 4, lat, data);
        check("t5_miss_data", data, 64'h3030);
        check("t5_busy_at_resp", 64'(flush_busy), 0);
        busy = 0; inv = 0;
        for (int c = 0; c < 9000; c++) begin
            @(posedge clk); #1;
            flush_req = (busy == 100);
            if (flush_busy) busy++;
            else if (busy > 0) break;
            if (cache_inv) inv++;
        end
        flush_req = 1'b0;
        check("t5_busy_cycles", 64'(busy), 8192);
        check("t5_inv_cycles", 64'(inv), 8192);
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (flush_busy) extra++;
        end
        check("t5_no_reflush", 64'(extra), 0);
        bfm_lat = 3; bfm_data = 64'h5A5A;
        do_req(0, 0, 36'hFFF80000, 0, lat, data, nm);
        check("t5_after_miss", 64'(nm), 1);
        check("t5_after_data", data, 64'h5A5A);

        // 6: reset while waiting on memory
        bfm_lat = 50; bfm_data = 64'h6666;
        issue(0, 0, 36'h500, 0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_outputs", 64'(|{req_ready, resp_valid, resp_data, flush_busy,
              cache_we, cache_inv, cache_addr_in, cache_addr_out, cache_data_in,
              mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        extra = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (resp_valid != 2'b00 || mem_req_valid) extra++;
        end
        check("t6_no_resp", 64'(extra), 0);
        bfm_lat = 3; bfm_data = 64'h6C;
        do_req(0, 0, 36'h40, 0, lat, data, nm);
        check("t6_cold_miss", 64'(nm), 1);
        check("t6_cold_data", data, 64'h6C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
